mm_lsu: RTL and testbench

//  Memory-access (MM) stage load/store unit, directly upstream of mm_wb.

---
 rtl/mm_lsu_pkg.sv | 26 ++
 rtl/mm_lsu_if.sv | 22 ++
 rtl/mm_align.sv | 51 +++++
 rtl/mm_lsu.sv | 179 +++++++++++++++++
 tb/tb_mm_lsu.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_lsu_pkg.sv
// Shared types and constants for the MM-stage load/store unit.
package mm_lsu_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // EX/MM values captured when an access is issued; addr[1:0] lives in result[1:0].
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  regdst;
    logic        memtoreg;
    logic        regwrite;
    logic [1:0]  size;
    logic        uns;
  } lat_t;

endpackage

// File: rtl/mm_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and data memory (slave).
// dm_req is held with stable dm_we/addr/wdata/be until the cycle dm_ack is sampled high (or abort);
// dm_rdata is only meaningful in a cycle where dm_ack = 1.
interface mm_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mm_align.sv
// Combinational lane logic: store data replication and byte enables, misalignment detection,
// and load byte/half extraction with sign or zero extension.
module mm_align
  import mm_lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic        st_misalign_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o    = st_wdata_i;
    st_be_o       = 4'b1111;
    st_misalign_o = 1'b0;
    case (st_size_i)
      SIZE_BYTE: begin
        st_wdata_o = {4{st_wdata_i[7:0]}};
        st_be_o    = 4'b0001 << st_addr_i;
      end
      SIZE_HALF: begin
        st_wdata_o    = {2{st_wdata_i[15:0]}};
        st_be_o       = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_misalign_o = st_addr_i[0];
      end
      SIZE_WORD: st_misalign_o = |st_addr_i;
      default:   st_misalign_o = |st_addr_i;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
    ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      SIZE_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mm_lsu.sv
// MM-stage load/store unit: issues data-memory accesses, stalls the front of the pipeline
// while one is outstanding, and presents aligned results to mm_wb.
module mm_lsu
  import mm_lsu_pkg::*;
#(
  parameter int DM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [31:0]     ex_result,
  input  logic [31:0]     ex_wdata,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [4:0]      ex_regdst,
  input  logic            ex_memtoreg,
  input  logic            ex_regwrite,
  mm_lsu_if.master        dm,
  output logic [31:0]     mm_mmdata,
  output logic [31:0]     mm_result,
  output logic [4:0]      mm_regdst,
  output logic            mm_memtoreg,
  output logic            mm_regwrite,
  output logic            mm_stall,
  output logic            mm_misalign,
  output logic            mm_buserr,
  output state_e          dbg_state_o
);

  localparam int CW = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   buf_q, buf_d;
  lat_t          lat_q, lat_d;
  logic          fault_q, fault_d;

  logic          memop;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic          st_misalign;
  logic [31:0]   ld_data;

  assign memop = ex_valid & (ex_memread | ex_memwrite);

  mm_align u_align (
    .st_size_i     (ex_size),
    .st_addr_i     (ex_result[1:0]),
    .st_wdata_i    (ex_wdata),
    .st_wdata_o    (st_wdata),
    .st_be_o       (st_be),
    .st_misalign_o (st_misalign),
    .ld_size_i     (lat_q.size),
    .ld_addr_i     (lat_q.result[1:0]),
    .ld_unsigned_i (lat_q.uns),
    .ld_rdata_i    (buf_q),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= ZeroWord;
      wdata_q <= ZeroWord;
      buf_q   <= ZeroWord;
      lat_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      lat_q   <= lat_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    lat_d       = lat_q;
    fault_d     = fault_q;
    mm_mmdata   = ZeroWord;
    mm_result   = lat_q.result;
    mm_regdst   = lat_q.regdst;
    mm_memtoreg = lat_q.memtoreg;
    mm_regwrite = 1'b0;
    mm_stall    = 1'b0;
    mm_misalign = 1'b0;
    mm_buserr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        mm_result   = ex_result;
        mm_regdst   = ex_regdst;
        mm_memtoreg = ex_memtoreg;
        if (!memop) begin
          mm_regwrite = ex_regwrite & ex_valid;
        end else if (st_misalign) begin
          mm_misalign = 1'b1;
        end else begin
          mm_stall        = 1'b1;
          req_d           = 1'b1;
          we_d            = ex_memwrite;
          addr_d          = {ex_result[31:2], 2'b00};
          be_d            = st_be;
          wdata_d         = st_wdata;
          lat_d.result    = ex_result;
          lat_d.regdst    = ex_regdst;
          lat_d.memtoreg  = ex_memtoreg;
          lat_d.regwrite  = ex_regwrite;
          lat_d.size      = ex_size;
          lat_d.uns       = ex_unsigned;
          fault_d         = 1'b0;
          cnt_d           = '0;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        mm_stall = 1'b1;
        if (dm.dm_ack) begin
          buf_d   = dm.dm_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        mm_mmdata   = ld_data;
        mm_regwrite = lat_q.regwrite & ~fault_q;
        mm_buserr   = fault_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs read as quiescent while reset is asserted.
    if (!rst) begin
      mm_stall    = 1'b0;
      mm_misalign = 1'b0;
      mm_buserr   = 1'b0;
    end
  end

  assign dm.dm_req    = req_q;
  assign dm.dm_we     = we_q;
  assign dm.dm_addr   = addr_q;
  assign dm.dm_wdata  = wdata_q;
  assign dm.dm_be     = be_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mm_lsu.sv
// Self-checking bench for mm_lsu: directed scenarios plus randomized accesses against a
// lane/extension model built from plain arithmetic.
module tb_mm_lsu;
  import mm_lsu_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_wdata;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_regdst;
  logic        ex_memtoreg;
  logic        ex_regwrite;
  logic [31:0] mm_mmdata;
  logic [31:0] mm_result;
  logic [4:0]  mm_regdst;
  logic        mm_memtoreg;
  logic        mm_regwrite;
  logic        mm_stall;
  logic        mm_misalign;
  logic        mm_buserr;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mm_lsu_if dm_bus ();

  mm_lsu #(.DM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_wdata(ex_wdata),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .dm(dm_bus),
    .mm_mmdata(mm_mmdata), .mm_result(mm_result), .mm_regdst(mm_regdst),
    .mm_memtoreg(mm_memtoreg), .mm_regwrite(mm_regwrite), .mm_stall(mm_stall),
    .mm_misalign(mm_misalign), .mm_buserr(mm_buserr), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return a != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return 4'(3 << (a & 2'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a,
                                         input logic [1:0] sz, input logic uns);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (rd >> (8 * (a & 2'd2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_result = '0; ex_wdata = '0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_size = 2'd0; ex_unsigned = 1'b0; ex_regdst = '0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
  endtask

  // Entered and left at posedge+1; comb outputs are sampled at the following negedge.
  task automatic alu_op(input logic valid, input logic [31:0] res, input logic rw, input logic [4:0] rdst);
    idle_inputs();
    ex_valid = valid; ex_result = res; ex_regwrite = rw; ex_regdst = rdst;
    #4;
    checks++; if (mm_result !== res) begin failures++; $display("FAIL alu_result got=%h exp=%h", mm_result, res); end
    checks++; if (mm_regwrite !== (rw & valid)) begin failures++; $display("FAIL alu_regwrite got=%b exp=%b", mm_regwrite, rw & valid); end
    checks++; if (mm_regdst !== rdst) begin failures++; $display("FAIL alu_regdst got=%0d exp=%0d", mm_regdst, rdst); end
    checks++; if ({mm_stall, dm_bus.dm_req, mm_misalign} !== 3'b000) begin failures++; $display("FAIL alu_quiet stall/req/mis got=%b exp=000", {mm_stall, dm_bus.dm_req, mm_misalign}); end
    checks++; if (mm_mmdata !== 32'h0) begin failures++; $display("FAIL alu_mmdata got=%h exp=0", mm_mmdata); end
    @(posedge clk); #1;
  endtask

  // ack_delay: extra WAIT cycles before dm_ack; negative means never acknowledge.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input logic [1:0] size, input logic uns, input logic rw,
                           input logic [4:0] rdst, input int ack_delay, input logic [31:0] rdata);
    int stalls;
    int waits;
    bit done;
    bit mis;
    bit fault;
    logic [31:0] exp_d;
    stalls = 0; waits = 0; done = 0;
    mis = m_misaligned(size, addr[1:0]);
    fault = (ack_delay < 0) || (ack_delay >= TO);
    ex_valid = 1'b1; ex_result = addr; ex_wdata = wdata; ex_memread = !wr; ex_memwrite = wr;
    ex_size = size; ex_unsigned = uns; ex_regdst = rdst; ex_memtoreg = !wr; ex_regwrite = rw;
    if (!wr && !mis && !fault) exp_q.push_back(m_load(rdata, addr[1:0], size, uns));
    #4;
    if (mis) begin
      checks++; if (mm_misalign !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", mm_misalign); end
      checks++; if (mm_stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", mm_stall); end
      checks++; if (mm_regwrite !== 1'b0) begin failures++; $display("FAIL mis_regwrite got=%b exp=0", mm_regwrite); end
      @(posedge clk); #1;
      idle_inputs();
      #4;
      checks++; if ({dm_bus.dm_req, mm_misalign} !== 2'b00) begin failures++; $display("FAIL mis_after req/mis got=%b exp=00", {dm_bus.dm_req, mm_misalign}); end
      @(posedge clk); #1;
      return;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (!mm_stall) begin
        done = 1;
      end else begin
        stalls++;
        checks++; if (mm_regwrite !== 1'b0) begin failures++; $display("FAIL stall_regwrite got=%b exp=0", mm_regwrite); end
        if (dm_bus.dm_req === 1'b1) begin
          waits++;
          if (waits == 1) begin
            checks++; if (dm_bus.dm_addr !== {addr[31:2], 2'b00}) begin failures++; $display("FAIL dm_addr got=%h exp=%h", dm_bus.dm_addr, {addr[31:2], 2'b00}); end
            checks++; if (dm_bus.dm_we !== wr) begin failures++; $display("FAIL dm_we got=%b exp=%b", dm_bus.dm_we, wr); end
            checks++; if (dm_bus.dm_be !== m_be(size, addr[1:0])) begin failures++; $display("FAIL dm_be got=%b exp=%b", dm_bus.dm_be, m_be(size, addr[1:0])); end
            if (wr) begin
              checks++; if (dm_bus.dm_wdata !== m_wdata(size, wdata)) begin failures++; $display("FAIL dm_wdata got=%h exp=%h", dm_bus.dm_wdata, m_wdata(size, wdata)); end
            end
          end
          if (ack_delay >= 0 && waits == ack_delay + 1) begin
            dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = rdata;
          end
        end
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = $urandom();
        #4;
      end
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL stall_bound: stall still high after 40 cycles");
      @(posedge clk); #1; idle_inputs();
      return;
    end
    checks++; if (stalls != (fault ? TO + 1 : ack_delay + 2)) begin failures++; $display("FAIL stall_cycles got=%0d exp=%0d", stalls, fault ? TO + 1 : ack_delay + 2); end
    checks++; if (waits != (fault ? TO : ack_delay + 1)) begin failures++; $display("FAIL wait_cycles got=%0d exp=%0d", waits, fault ? TO : ack_delay + 1); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin failures++; $display("FAIL done_req got=%b exp=0", dm_bus.dm_req); end
    checks++; if (mm_buserr !== fault) begin failures++; $display("FAIL done_buserr got=%b exp=%b", mm_buserr, fault); end
    checks++; if (mm_regwrite !== (rw & !fault)) begin failures++; $display("FAIL done_regwrite got=%b exp=%b", mm_regwrite, rw & !fault); end
    checks++; if ({mm_result, mm_regdst, mm_memtoreg} !== {addr, rdst, !wr}) begin failures++; $display("FAIL done_ctrl got=%h/%0d/%b exp=%h/%0d/%b", mm_result, mm_regdst, mm_memtoreg, addr, rdst, !wr); end
    if (!wr && !fault) begin
      exp_d = exp_q.pop_front();
      checks++; if (mm_mmdata !== exp_d) begin failures++; $display("FAIL done_mmdata got=%h exp=%h", mm_mmdata, exp_d); end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; idle_inputs(); dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #4;
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if ({dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_be} !== 6'b0) begin failures++; $display("FAIL reset_req_we_be got=%b exp=0", {dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_be}); end
    checks++; if ({dm_bus.dm_addr, dm_bus.dm_wdata} !== 64'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h exp=0", {dm_bus.dm_addr, dm_bus.dm_wdata}); end
    checks++; if ({mm_stall, mm_misalign, mm_buserr} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {mm_stall, mm_misalign, mm_buserr}); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    alu_op(1'b1, 32'h0000_1234, 1'b1, 5'd7);
    alu_op(1'b0, 32'hDEAD_BEEF, 1'b1, 5'd3);
    for (int i = 0; i < 4; i++) alu_op(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  task automatic test_load_byte();
    do_access(32'h0000_0103, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd4, 0, 32'h80FF_7F01);
    do_access(32'h0000_0103, 32'h0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 0, 32'h80FF_7F01);
    do_access(32'h0000_0106, 32'h0, 1'b0, 2'd1, 1'b0, 1'b1, 5'd5, 2, 32'h8001_7FFF);
  endtask

  task automatic test_store_half();
    do_access(32'h0000_0202, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 1, 32'h0);
    do_access(32'h0000_0301, 32'h1234_5678, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
  endtask

  task automatic test_misalign();
    do_access(32'h0000_0101, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 0, 32'h0);
    do_access(32'h0000_0203, 32'h0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 0, 32'h0);
    do_access(32'h0000_0402, 32'h0, 1'b0, 2'd3, 1'b0, 1'b1, 5'd9, 0, 32'h0);
  endtask

  task automatic test_timeout();
    do_access(32'h0000_0500, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd11, -1, 32'h0);
    do_access(32'h0000_0504, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd12, TO - 1, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_wait();
    ex_valid = 1'b1; ex_result = 32'h0000_0300; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_size = 2'd2; ex_regwrite = 1'b1; ex_memtoreg = 1'b1; ex_regdst = 5'd2;
    #4;
    @(posedge clk); #5;
    checks++; if (dm_bus.dm_req !== 1'b1) begin failures++; $display("FAIL rmw_req_before got=%b exp=1", dm_bus.dm_req); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; idle_inputs();
    #4;
    checks++; if (dm_bus.dm_req !== 1'b0) begin failures++; $display("FAIL rmw_req_after got=%b exp=0", dm_bus.dm_req); end
    checks++; if (mm_stall !== 1'b0) begin failures++; $display("FAIL rmw_stall got=%b exp=0", mm_stall); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rmw_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(posedge clk); #1;
    do_access(32'h0000_0300, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd2, 1, 32'h1357_9BDF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        alu_op(1'b1, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end else begin
        do_access($urandom(), $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom());
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
